// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply sequencer and the Booth multiplier beside it.
package hilo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Load cycle plus one Booth iteration per operand bit; the multiplier uses the same count.
    localparam int MULT_CYCLES_DEF = 33;

endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// Control-unit side of the HI/LO block: multiply request, MTHI/MTLO writes, HI/LO readback, status.
interface hilo_mult_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, op_a, op_b, mthi, mtlo, wdata,
        input  hi, lo, busy, done, err
    );

    modport slave (
        input  start, op_a, op_b, mthi, mtlo, wdata,
        output hi, lo, busy, done, err
    );
endinterface

// File: rtl/hilo_mult_ctrl.sv
// Sequences the Booth multiplier (restart, wait fixed latency, capture) and holds architectural HI/LO.
module hilo_mult_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic              clock,
    input  logic              reset,
    hilo_mult_ctrl_if.slave   bus,
    output logic              mult_rst,
    output logic [WIDTH-1:0]  mult_a,
    output logic [WIDTH-1:0]  mult_b,
    input  logic [WIDTH-1:0]  mult_hi,
    input  logic [WIDTH-1:0]  mult_lo
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             err_q;
    logic             ready;
    logic             start_ok;
    logic             wr_ok;
    logic             conflict;

    // DONE is an idle state that merely flags the fresh result for one cycle.
    assign ready    = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok = ready && bus.start;
    assign wr_ok    = ready && !bus.start;
    assign conflict = (!ready && (bus.start || bus.mthi || bus.mtlo)) ||
                      (ready && bus.start && (bus.mthi || bus.mtlo));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = bus.start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR:         state_nxt = ST_RUN;
            ST_RUN:           state_nxt = (cnt == '0) ? ST_WRITE : ST_RUN;
            ST_WRITE:         state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mult_a <= '0;
            mult_b <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= conflict;
            if (start_ok) begin
                mult_a <= bus.op_a;
                mult_b <= bus.op_b;
            end
            if (state == ST_CLEAR)
                cnt <= CNT_W'(MULT_CYCLES - 1);
            else if (state == ST_RUN)
                cnt <= cnt - 1'b1;
            // Writes arriving while busy were already rejected, so the product always lands intact.
            if (state == ST_WRITE) begin
                hi_q <= mult_hi;
                lo_q <= mult_lo;
            end else if (wr_ok) begin
                if (bus.mthi) hi_q <= bus.wdata;
                if (bus.mtlo) lo_q <= bus.wdata;
            end
        end
    end

    assign mult_rst = reset || (state == ST_CLEAR);
    assign bus.busy = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_WRITE);
    assign bus.done = (state == ST_DONE);
    assign bus.err  = err_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl with a latency-accurate stand-in for the Booth multiplier.
module tb_hilo_mult_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mult_rst;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    int          total = 0;
    int          bad = 0;

    hilo_mult_ctrl_if #(.WIDTH(32)) bus ();

    hilo_mult_ctrl #(.WIDTH(32), .MULT_CYCLES(33), .CNT_W(6)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .mult_rst (mult_rst),
        .mult_a   (mult_a),
        .mult_b   (mult_b),
        .mult_hi  (mult_hi),
        .mult_lo  (mult_lo)
    );

    always #5 clock = ~clock;

    // Multiplier stand-in: garbage until 33 cycles after its reset drops, then the true product.
    logic [6:0]  mcnt;
    logic [63:0] prod;
    always @(posedge clock) begin
        if (mult_rst) mcnt <= 7'd0;
        else if (mcnt < 7'd33) mcnt <= mcnt + 7'd1;
    end
    assign prod = longint'($signed(mult_a)) * longint'($signed(mult_b));
    assign {mult_hi, mult_lo} = (mcnt == 7'd33) ? prod : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.wdata = '0;
    endtask

    // Issues a start and counts busy cycles; leaves the bench in the cycle after busy drops.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, output int nb);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nb = 0;
        for (int i = 0; i < 100 && bus.busy; i++) begin
            nb++;
            tick();
        end
    endtask

    task automatic test_reset();
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", bus.err); end
        total++; if (mult_rst !== 1'b1) begin bad++; $display("FAIL reset_mult_rst got %b want 1", mult_rst); end
        total++; if ({mult_a, mult_b} !== 64'd0) begin bad++; $display("FAIL reset_ops got %h want 0", {mult_a, mult_b}); end
        reset = 1'b0;
        tick();
        total++; if (mult_rst !== 1'b0) begin bad++; $display("FAIL idle_mult_rst got %b want 0", mult_rst); end
    endtask

    task automatic test_mult_7x6();
        int nb;
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (mult_rst !== 1'b1) begin bad++; $display("FAIL clear_mult_rst got %b want 1", mult_rst); end
        total++; if (mult_a !== 32'd7 || mult_b !== 32'd6) begin bad++; $display("FAIL latch_ops got %h/%h want 7/6", mult_a, mult_b); end
        nb = 0;
        for (int i = 0; i < 100 && bus.busy; i++) begin
            nb++;
            tick();
        end
        total++; if (nb !== 35) begin bad++; $display("FAIL busy_len got %0d want 35", nb); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL done_pulse got %b want 1", bus.done); end
        total++; if ({bus.hi, bus.lo} !== 64'd42) begin bad++; $display("FAIL prod_7x6 got %h want 42", {bus.hi, bus.lo}); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_width got %b want 0", bus.done); end
        total++; if (mult_a !== 32'd7) begin bad++; $display("FAIL ops_held got %h want 7", mult_a); end
    endtask

    task automatic test_mult_signed();
        int nb;
        run_mult(32'hFFFF_FFFD, 32'd5, nb);
        total++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL prod_neg got %h want FFFFFFFFFFFFFFF1", {bus.hi, bus.lo}); end
        run_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, nb);
        total++; if (bus.hi !== 32'h3FFF_FFFF) begin bad++; $display("FAIL prod_max_hi got %h want 3FFFFFFF", bus.hi); end
        total++; if (bus.lo !== 32'h0000_0001) begin bad++; $display("FAIL prod_max_lo got %h want 00000001", bus.lo); end
        tick();
    endtask

    task automatic test_mtx();
        int nb;
        bus.wdata = 32'hDEAD_BEEF;
        bus.mthi  = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        total++; if (bus.hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mthi got %h want DEADBEEF", bus.hi); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mthi_err got %b want 0", bus.err); end
        bus.wdata = 32'h0000_1234;
        bus.mtlo  = 1'b1;
        tick();
        bus.mtlo  = 1'b0;
        total++; if (bus.lo !== 32'h0000_1234) begin bad++; $display("FAIL mtlo got %h want 00001234", bus.lo); end
        total++; if (bus.hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mtlo_keeps_hi got %h want DEADBEEF", bus.hi); end
        bus.wdata = 32'h0000_0055;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        total++; if ({bus.hi, bus.lo} !== 64'h0000_0055_0000_0055) begin bad++; $display("FAIL mt_both got %h want 0000005500000055", {bus.hi, bus.lo}); end
        // Start and MTHI together: the multiply proceeds and the write is dropped.
        bus.wdata = 32'hCAFE_0000;
        bus.mthi  = 1'b1;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL start_mt_err got %b want 1", bus.err); end
        total++; if (bus.hi !== 32'h0000_0055) begin bad++; $display("FAIL start_mt_hi got %h want 00000055", bus.hi); end
        nb = 0;
        for (int i = 0; i < 100 && !bus.done; i++) begin
            nb++;
            tick();
        end
        total++; if ({bus.hi, bus.lo} !== 64'd12) begin bad++; $display("FAIL start_mt_prod got %h want 12", {bus.hi, bus.lo}); end
        tick();
    endtask

    task automatic test_conflicts();
        int nb;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.op_a  = 32'd100;
        bus.op_b  = 32'd100;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL busy_start_err got %b want 1", bus.err); end
        total++; if (mult_a !== 32'd9 || mult_b !== 32'd9) begin bad++; $display("FAIL busy_start_ops got %h/%h want 9/9", mult_a, mult_b); end
        tick();
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_width got %b want 0", bus.err); end
        bus.wdata = 32'hFFFF_0000;
        bus.mthi  = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL busy_mthi_err got %b want 1", bus.err); end
        total++; if (bus.hi === 32'hFFFF_0000) begin bad++; $display("FAIL busy_mthi_dropped got %h want not FFFF0000", bus.hi); end
        nb = 0;
        for (int i = 0; i < 100 && !bus.done; i++) begin
            nb++;
            tick();
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL conflict_done got %b want 1", bus.done); end
        total++; if ({bus.hi, bus.lo} !== 64'd81) begin bad++; $display("FAIL conflict_prod got %h want 81", {bus.hi, bus.lo}); end
        // DONE accepts register writes like IDLE.
        bus.wdata = 32'd77;
        bus.mtlo  = 1'b1;
        tick();
        bus.mtlo  = 1'b0;
        total++; if (bus.lo !== 32'd77) begin bad++; $display("FAIL done_mtlo got %h want 0000004d", bus.lo); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL done_mtlo_err got %b want 0", bus.err); end
    endtask

    task automatic test_reset_mid();
        int  nb;
        logic seen_done;
        bus.wdata = 32'h1111_2222;
        bus.mthi  = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        bus.op_a  = 32'd11;
        bus.op_b  = 32'd13;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        reset = 1'b1;
        #1;
        total++; if ({bus.hi, bus.lo} !== 64'd0) begin bad++; $display("FAIL midrst_hilo got %h want 0", {bus.hi, bus.lo}); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        total++; if (mult_a !== 32'd0) begin bad++; $display("FAIL midrst_ops got %h want 0", mult_a); end
        tick();
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 45; i++) begin
            seen_done = seen_done | bus.done;
            tick();
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got %b want 0", seen_done); end
        total++; if ({bus.hi, bus.lo} !== 64'd0) begin bad++; $display("FAIL midrst_no_capture got %h want 0", {bus.hi, bus.lo}); end
        run_mult(32'd2, 32'd2, nb);
        total++; if (bus.lo !== 32'd4 || bus.hi !== 32'd0) begin bad++; $display("FAIL after_rst_prod got %h/%h want 0/4", bus.hi, bus.lo); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        test_reset();
        test_mult_7x6();
        test_mult_signed();
        test_mtx();
        test_conflicts();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
